mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 27 ++
 rtl/mem_arbiter.sv | 98 +++++++++
 tb/tb_mem_arbiter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus between the memory arbiter and its environment (fetch, load/store, memory).
// The arbiter connects through 'master'; the requesters and memory model use 'slave'.
interface mem_arbiter_if;
    logic ifReq;
    logic lsReq;
    logic lsRW;
    logic MFC;
    logic ifGnt;
    logic lsGnt;
    logic MARsel;
    logic MARload;
    logic MEMEn;
    logic MEMR_W;
    logic ifDone;
    logic lsDone;
    logic busErr;

    modport master (
        input  ifReq, lsReq, lsRW, MFC,
        output ifGnt, lsGnt, MARsel, MARload, MEMEn, MEMR_W, ifDone, lsDone, busErr
    );

    modport slave (
        output ifReq, lsReq, lsRW, MFC,
        input  ifGnt, lsGnt, MARsel, MARload, MEMEn, MEMR_W, ifDone, lsDone, busErr
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter (instruction fetch vs load/store) with round-robin
// tie-break, Moore-decoded bus controls and an MFC timeout that raises busErr.
//
// state    | meaning
// IDLE     | no owner; arbitrate pending requests
// LOAD_MAR | owner chosen; load MAR from the owner's address
// ACCESS   | memory enabled; wait for MFC or timeout
// COMPLETE | MFC seen; done pulse to owner
// ERROR    | timed out; done pulse plus busErr to owner
module mem_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.master bus
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] LOAD_MAR = 3'd1;
    localparam logic [2:0] ACCESS   = 3'd2;
    localparam logic [2:0] COMPLETE = 3'd3;
    localparam logic [2:0] ERROR    = 3'd4;

    localparam logic [3:0] LAST_WAIT = 4'(TIMEOUT - 1);

    logic [2:0] state;
    logic [2:0] stateNext;
    logic       gntLs;     // 0 = fetch owns the bus, 1 = load/store
    logic       lastGnt;   // owner of the most recently finished transaction
    logic       dirRead;
    logic [3:0] waitCnt;
    logic       anyReq;
    logic       pickLs;
    logic       busy;
    logic       done;

    always_comb begin
        anyReq = bus.ifReq || bus.lsReq;
        pickLs = (bus.ifReq && bus.lsReq) ? ~lastGnt : bus.lsReq;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:     if (anyReq) stateNext = LOAD_MAR;
            LOAD_MAR: stateNext = ACCESS;
            ACCESS: begin
                // MFC wins over a timeout landing in the same cycle
                if (bus.MFC)                   stateNext = COMPLETE;
                else if (waitCnt == LAST_WAIT) stateNext = ERROR;
            end
            COMPLETE: stateNext = IDLE;
            ERROR:    stateNext = IDLE;
            default:  stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            gntLs   <= 1'b0;
            lastGnt <= 1'b1;
            dirRead <= 1'b1;
            waitCnt <= 4'd0;
        end else begin
            state <= stateNext;
            case (state)
                IDLE: begin
                    if (anyReq) begin
                        gntLs   <= pickLs;
                        dirRead <= pickLs ? bus.lsRW : 1'b1;
                    end
                end
                LOAD_MAR: waitCnt <= 4'd0;
                ACCESS:   waitCnt <= waitCnt + 4'd1;
                COMPLETE: lastGnt <= gntLs;
                ERROR:    lastGnt <= gntLs;
                default:  ;
            endcase
        end
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == COMPLETE) || (state == ERROR);
    end

    assign bus.ifGnt   = busy && !gntLs;
    assign bus.lsGnt   = busy && gntLs;
    assign bus.MARsel  = busy && gntLs;
    assign bus.MARload = (state == LOAD_MAR);
    assign bus.MEMEn   = (state == ACCESS);
    assign bus.MEMR_W  = (state == ACCESS) ? dirRead : 1'b1;
    assign bus.ifDone  = done && !gntLs;
    assign bus.lsDone  = done && gntLs;
    assign bus.busErr  = (state == ERROR);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: each step drives inputs, compares the packed
// output vector against a hand-written expectation, then advances one clock.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    mem_arbiter_if bus ();

    mem_arbiter #(.TIMEOUT(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // bit order: ifGnt lsGnt MARsel MARload MEMEn MEMR_W ifDone lsDone busErr
    localparam logic [8:0] IDLE_O  = 9'b0_0_0_0_0_1_0_0_0;
    localparam logic [8:0] F_LOAD  = 9'b1_0_0_1_0_1_0_0_0;
    localparam logic [8:0] F_ACC_R = 9'b1_0_0_0_1_1_0_0_0;
    localparam logic [8:0] F_DONE  = 9'b1_0_0_0_0_1_1_0_0;
    localparam logic [8:0] L_LOAD  = 9'b0_1_1_1_0_1_0_0_0;
    localparam logic [8:0] L_ACC_W = 9'b0_1_1_0_1_0_0_0_0;
    localparam logic [8:0] L_ACC_R = 9'b0_1_1_0_1_1_0_0_0;
    localparam logic [8:0] L_DONE  = 9'b0_1_1_0_0_1_0_1_0;
    localparam logic [8:0] L_ERR   = 9'b0_1_1_0_0_1_0_1_1;

    localparam logic [8:0] TIE_SEQ [0:7] = '{F_LOAD, F_ACC_R, F_DONE, IDLE_O,
                                              L_LOAD, L_ACC_R, L_DONE, IDLE_O};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [8:0] exp);
        logic [8:0] obs;
        obs = {bus.ifGnt, bus.lsGnt, bus.MARsel, bus.MARload, bus.MEMEn,
               bus.MEMR_W, bus.ifDone, bus.lsDone, bus.busErr};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        reset     = 1'b1;
        bus.ifReq = 1'b0;
        bus.lsReq = 1'b0;
        bus.lsRW  = 1'b1;
        bus.MFC   = 1'b0;
        tick();
        tick();
        chk("reset", IDLE_O);

        // fetch read, MFC on first ACCESS cycle
        reset = 1'b0;
        bus.ifReq = 1'b1;
        chk("f_idle", IDLE_O);
        tick();
        bus.ifReq = 1'b0;
        chk("f_load", F_LOAD);
        tick();
        bus.MFC = 1'b1;
        chk("f_acc", F_ACC_R);
        tick();
        bus.MFC = 1'b0;
        chk("f_done", F_DONE);
        tick();
        chk("f_idle2", IDLE_O);

        // store, MFC on the third ACCESS cycle
        bus.lsReq = 1'b1;
        bus.lsRW  = 1'b0;
        tick();
        bus.lsReq = 1'b0;
        chk("st_load", L_LOAD);
        tick();
        chk("st_acc0", L_ACC_W);
        tick();
        chk("st_acc1", L_ACC_W);
        tick();
        bus.MFC = 1'b1;
        chk("st_acc2", L_ACC_W);
        tick();
        bus.MFC = 1'b0;
        chk("st_done", L_DONE);
        tick();
        chk("st_idle", IDLE_O);

        // MFC in IDLE without a request is ignored
        bus.MFC = 1'b1;
        tick();
        chk("mfc_idle", IDLE_O);

        // tie fairness out of reset; MFC held high also exercises MFC in LOAD_MAR
        reset     = 1'b1;
        bus.ifReq = 1'b1;
        bus.lsReq = 1'b1;
        bus.lsRW  = 1'b1;
        tick();
        reset = 1'b0;
        chk("tie_reset", IDLE_O);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 8; i++) begin
                tick();
                chk($sformatf("tie_r%0d_s%0d", r, i), TIE_SEQ[i]);
            end
        end
        bus.ifReq = 1'b0;
        bus.lsReq = 1'b0;
        bus.MFC   = 1'b0;
        tick();
        chk("tie_quiet", IDLE_O);

        // timeout: 15 ACCESS cycles then ERROR
        bus.lsReq = 1'b1;
        bus.lsRW  = 1'b1;
        tick();
        bus.lsReq = 1'b0;
        chk("to_load", L_LOAD);
        for (int i = 0; i < 15; i++) begin
            tick();
            chk($sformatf("to_acc%0d", i), L_ACC_R);
        end
        tick();
        chk("to_err", L_ERR);
        tick();
        chk("to_idle", IDLE_O);

        // MFC on the last allowed ACCESS cycle beats the timeout
        bus.ifReq = 1'b1;
        tick();
        bus.ifReq = 1'b0;
        chk("pri_load", F_LOAD);
        for (int i = 0; i < 14; i++) begin
            tick();
            chk($sformatf("pri_acc%0d", i), F_ACC_R);
        end
        tick();
        bus.MFC = 1'b1;
        chk("pri_acc14", F_ACC_R);
        tick();
        bus.MFC = 1'b0;
        chk("pri_done", F_DONE);
        tick();
        chk("pri_idle", IDLE_O);

        // reset during ACCESS abandons the fetch
        bus.ifReq = 1'b1;
        tick();
        bus.ifReq = 1'b0;
        chk("rst_load", F_LOAD);
        tick();
        reset = 1'b1;
        chk("rst_acc", F_ACC_R);
        tick();
        reset = 1'b0;
        chk("rst_abort", IDLE_O);
        tick();
        chk("rst_nodone", IDLE_O);
        bus.ifReq = 1'b1;
        tick();
        bus.ifReq = 1'b0;
        chk("rst_f_load", F_LOAD);
        tick();
        bus.MFC = 1'b1;
        chk("rst_f_acc", F_ACC_R);
        tick();
        bus.MFC = 1'b0;
        chk("rst_f_done", F_DONE);
        tick();
        chk("rst_f_idle", IDLE_O);

        // one-cycle lsReq pulse, lsRW toggling after the grant
        bus.lsReq = 1'b1;
        bus.lsRW  = 1'b1;
        tick();
        bus.lsReq = 1'b0;
        bus.lsRW  = 1'b0;
        chk("wd_load", L_LOAD);
        tick();
        chk("wd_acc0", L_ACC_R);
        bus.lsRW = 1'b1;
        tick();
        bus.lsRW = 1'b0;
        bus.MFC  = 1'b1;
        chk("wd_acc1", L_ACC_R);
        tick();
        bus.MFC = 1'b0;
        chk("wd_done", L_DONE);
        tick();
        chk("wd_idle", IDLE_O);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
